// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and default parameter values for the stopwatch control block.
//   sw_state_t      : FSM state encoding, also driven on stopwatch_ctrl.state
//   TICK_DIV_DEF    : default clk cycles per count tick (100 Hz at 100 MHz)
//   DEB_CYCLES_DEF  : default consecutive synced-high cycles to accept a press
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_PAUSE = 2'd2
  } sw_state_t;

  localparam int unsigned TICK_DIV_DEF   = 1_000_000;
  localparam int unsigned DEB_CYCLES_DEF = 4;

endpackage

// File: rtl/btn_cond.sv
// -----------------------------------------------------------------------------
// btn_cond
// Conditions one asynchronous push-button into a single-cycle press event:
// 2-flop synchronizer, debounce counter, and an arm flag so that one physical
// press yields exactly one event.
//   clk      : system clock
//   reset    : synchronous, active-high
//   i_btn    : raw asynchronous button level
//   o_press  : one-cycle press event
// Parameters:
//   DEB_CYCLES : consecutive synchronized-high cycles required (>= 1)
// -----------------------------------------------------------------------------
module btn_cond
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEB_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic [1:0]    r_vld;    // fills with 1s after reset: r_sync2 holds a real sample once r_vld[1] is set
  logic [CW-1:0] r_cnt;
  logic          r_armed;
  logic          w_press;

  // Event fires on the cycle the counter first reaches the threshold; the
  // counter saturates there and arm drops, so a long hold gives one pulse.
  assign w_press = r_armed && (r_cnt == CNT_DONE);
  assign o_press = w_press;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_vld   <= 2'b00;
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_vld   <= {r_vld[0], 1'b1};

      if (!r_sync2)
        r_cnt <= '0;
      else if (r_cnt != CNT_DONE)
        r_cnt <= r_cnt + CW'(1);

      // Arming needs a genuinely sampled low level; the zeros left in the
      // synchronizer by reset must not arm a button held through reset.
      if (w_press)
        r_armed <= 1'b0;
      else if (r_vld[1] && !r_sync2)
        r_armed <= 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Control FSM (IDLE/RUN/PAUSE) and timebase for the stopwatch datapath.
// Produces the count-enable tick, the counter clear pulse and display hold.
//   clk      : system clock, rising edge
//   reset    : synchronous, active-high
//   start    : start/resume button (async level)
//   stop     : stop/clear button (async level)
//   lap      : lap button (async level), only with STOPWATCH_LAP_EN defined
//   cnt_en   : one-cycle count pulse every TICK_DIV cycles while running
//   cnt_clr  : one-cycle clear pulse on PAUSE -> IDLE
//   hold     : display freeze (toggled by lap in RUN; 0 without the lap option)
//   running  : high while state is RUN
//   state    : current FSM state
// Build option: define STOPWATCH_LAP_EN to add the lap button and hold toggle.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      start,
  input  logic      stop,
`ifdef STOPWATCH_LAP_EN
  input  logic      lap,
`endif
  output logic      cnt_en,
  output logic      cnt_clr,
  output logic      hold,
  output logic      running,
  output sw_state_t state
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic w_start_ev;
  logic w_stop_ev;
  logic w_lap_ev;

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .clk(clk), .reset(reset), .i_btn(start), .o_press(w_start_ev)
  );

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_stop (
    .clk(clk), .reset(reset), .i_btn(stop), .o_press(w_stop_ev)
  );

`ifdef STOPWATCH_LAP_EN
  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_lap (
    .clk(clk), .reset(reset), .i_btn(lap), .o_press(w_lap_ev)
  );
`else
  assign w_lap_ev = 1'b0;
`endif

  sw_state_t        r_state;
  logic             r_running;
  logic [PRE_W-1:0] r_pre;
  logic             r_cnt_en;
  logic             r_cnt_clr;
  logic             r_hold;

  sw_state_t        w_state_nxt;
  logic [PRE_W-1:0] w_pre_nxt;
  logic             w_cnt_en_nxt;
  logic             w_cnt_clr_nxt;
  logic             w_hold_nxt;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_pre_nxt     = r_pre;
    w_cnt_en_nxt  = 1'b0;
    w_cnt_clr_nxt = 1'b0;
    w_hold_nxt    = r_hold;

    // The timebase follows the current state, so the edge that leaves RUN
    // still advances it and a wrap on that edge still emits its cnt_en.
    if (r_state == SW_RUN) begin
      w_cnt_en_nxt = (r_pre == PRE_LAST);
      w_pre_nxt    = (r_pre == PRE_LAST) ? '0 : r_pre + PRE_W'(1);
    end

    case (r_state)
      SW_IDLE: begin
        // A simultaneous stop discards the start.
        if (w_start_ev && !w_stop_ev) begin
          w_state_nxt = SW_RUN;
          w_pre_nxt   = '0;
        end
      end
      SW_RUN: begin
        if (w_stop_ev)
          w_state_nxt = SW_PAUSE;
        if (w_lap_ev)
          w_hold_nxt = !r_hold;
      end
      SW_PAUSE: begin
        if (w_stop_ev) begin
          w_state_nxt   = SW_IDLE;
          w_cnt_clr_nxt = 1'b1;
          w_hold_nxt    = 1'b0;
        end else if (w_start_ev) begin
          w_state_nxt = SW_RUN;
        end
      end
      default: begin
        w_state_nxt = SW_IDLE;
        w_hold_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= SW_IDLE;
      r_running <= 1'b0;
      r_pre     <= '0;
      r_cnt_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_hold    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == SW_RUN);
      r_pre     <= w_pre_nxt;
      r_cnt_en  <= w_cnt_en_nxt;
      r_cnt_clr <= w_cnt_clr_nxt;
      r_hold    <= w_hold_nxt;
    end
  end

  assign state   = r_state;
  assign running = r_running;
  assign cnt_en  = r_cnt_en;
  assign cnt_clr = r_cnt_clr;
  assign hold    = r_hold;

endmodule
